// File: rtl/mario_audio_i2s_tx.sv
// I2S transmitter: serialises the signed 16-bit mono mix onto SCLK/LRCK/DAC, same sample in both slots.
// Latency: sample captured in the O_FRAME_STB clock, its MSB appears on DAC at that clock edge.
// Backpressure: none; I_SND_DAT is free-running and only sampled at the frame load, one frame per 1000 clocks.
module mario_audio_i2s_tx #(
  parameter int ACC_INC = 16,
  parameter int ACC_MOD = 125,
  parameter int ACC_W   = 7
) (
  input  logic        I_CLK_48M,
  input  logic        I_RESETn,
  input  logic [15:0] I_SND_DAT,
  input  logic        I_MUTE,
  output logic        O_AUDIO_SCLK,
  output logic        O_AUDIO_LRCK,
  output logic        O_AUDIO_DAC,
  output logic        O_FRAME_STB
);

  // The sum carries one extra bit so acc+ACC_INC can never wrap before the
  // modulus compare, whatever ACC_W is chosen.
  localparam logic [ACC_W:0] C_INC = (ACC_W+1)'(ACC_INC);
  localparam logic [ACC_W:0] C_MOD = (ACC_W+1)'(ACC_MOD);

  logic [ACC_W-1:0] r_acc;
  logic [ACC_W:0]   w_sum;
  logic             w_tick;
  logic             w_fall;
  logic             w_load;
  logic             r_sclk;
  logic             r_lrck;
  logic             r_dac;
  logic [5:0]       r_bit_cnt;
  logic [5:0]       w_bit_nxt;
  // Only word[62:0] needs storing: word[63] goes straight to DAC on load.
  logic [62:0]      r_shift;
  logic [15:0]      w_smp;
  logic [63:0]      w_word;

  assign w_sum     = {1'b0, r_acc} + C_INC;
  assign w_tick    = (w_sum >= C_MOD);
  // A tick while SCLK is high is a falling edge: the only point where the
  // frame state advances.
  assign w_fall    = w_tick & r_sclk;
  assign w_bit_nxt = r_bit_cnt + 6'd1;
  assign w_load    = w_fall && (w_bit_nxt == 6'd1);

  // Frame word assembled from the live inputs; only consumed in the load clock,
  // so mute and data changes between loads never tear a frame.
  always_comb begin
    w_smp  = I_MUTE ? 16'h0000 : I_SND_DAT;
    w_word = {w_smp, 16'h0000, w_smp, 16'h0000};
  end

  // Fractional phase accumulator producing 16 ticks every 125 clocks.
  always_ff @(posedge I_CLK_48M or negedge I_RESETn) begin
    if (!I_RESETn) begin
      r_acc <= '0;
    end else begin
      r_acc <= ACC_W'(w_tick ? (w_sum - C_MOD) : w_sum);
    end
  end

  // Bit clock toggles on every tick.
  always_ff @(posedge I_CLK_48M or negedge I_RESETn) begin
    if (!I_RESETn) begin
      r_sclk <= 1'b0;
    end else if (w_tick) begin
      r_sclk <= ~r_sclk;
    end
  end

  // Falling ticks advance the 64-bit frame: word select, data bit and shifter.
  always_ff @(posedge I_CLK_48M or negedge I_RESETn) begin
    if (!I_RESETn) begin
      r_bit_cnt <= 6'd63;
      r_lrck    <= 1'b1;
      r_dac     <= 1'b0;
      r_shift   <= '0;
    end else if (w_fall) begin
      r_bit_cnt <= w_bit_nxt;
      r_lrck    <= w_bit_nxt[5];
      if (w_bit_nxt == 6'd1) begin
        // Left MSB goes out one bit after LRCK fell (I2S one-bit delay).
        r_dac   <= w_word[63];
        r_shift <= w_word[62:0];
      end else if (w_bit_nxt == 6'd0) begin
        // Final pad bit of the right slot, coincides with LRCK falling.
        r_dac   <= 1'b0;
      end else begin
        r_dac   <= r_shift[62];
        r_shift <= {r_shift[61:0], 1'b0};
      end
    end
  end

  assign O_AUDIO_SCLK = r_sclk;
  assign O_AUDIO_LRCK = r_lrck;
  assign O_AUDIO_DAC  = r_dac;
  // Strobe marks the clock whose closing edge captures the sample; it is
  // decoded from registered state only, so reset forces it low at once.
  assign O_FRAME_STB  = w_load;

endmodule

// File: tb/tb_mario_audio_i2s_tx.sv
// Bench for mario_audio_i2s_tx: closed-form timing model plus a frame scoreboard.
// Expected frames are pushed at the load edge from the inputs the bench drives.
// Outputs are sampled on the falling clock edge; inputs change at that edge too.
module tb_mario_audio_i2s_tx;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] snd;
  logic        mute;
  logic        sclk, lrck, dac, stb;

  always #5 clk = ~clk;

  mario_audio_i2s_tx #(.ACC_INC(16), .ACC_MOD(125), .ACC_W(7)) dut (
    .I_CLK_48M   (clk),
    .I_RESETn    (rst_n),
    .I_SND_DAT   (snd),
    .I_MUTE      (mute),
    .O_AUDIO_SCLK(sclk),
    .O_AUDIO_LRCK(lrck),
    .O_AUDIO_DAC (dac),
    .O_FRAME_STB (stb)
  );

  int checks = 0;
  int errors = 0;

  logic [63:0] exp_q[$];
  logic [63:0] obs;
  logic [63:0] last_frame;
  int          frames_done;
  int          bit_n;
  bit          live, armed, armed_load, collecting;
  logic        prev_sclk, prev_lrck;
  int          n_edge;
  int          tmis, tog, rises, stbs, first_rise, first_stb;
  int          last_stb, intervals, bad_int;
  int          seg_rises, seg_cnt, seg_bad;
  bit          seg_open;

  function automatic logic [63:0] frame_of(input logic [15:0] s, input logic m);
    logic [15:0] v;
    v = m ? 16'h0000 : s;
    return {v, 16'h0000, v, 16'h0000};
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, want);
    end
  endtask

  task automatic timeout(input string tag);
    checks++;
    errors++;
    $error("FAIL %s: timed out waiting for the DUT", tag);
  endtask

  task automatic check_frame();
    logic [63:0] want;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $error("FAIL frame: observed %0h expected nothing queued", obs);
    end else begin
      want = exp_q.pop_front();
      assert (obs === want) else begin
        errors++;
        $error("FAIL frame: observed %0h expected %0h", obs, want);
      end
    end
    last_frame = obs;
    frames_done++;
  endtask

  task automatic clear_stats();
    tmis = 0; tog = 0; rises = 0; stbs = 0; first_rise = -1; first_stb = -1;
  endtask

  task automatic bench_reset_state();
    live = 0; armed = 0; armed_load = 0; collecting = 0; bit_n = 0;
    exp_q.delete();
    n_edge = 0; prev_sclk = 1'b0; prev_lrck = 1'b1;
    last_stb = -1; seg_open = 0; seg_rises = 0;
  endtask

  // One clock: push at the load edge, then sample and check at the falling edge.
  task automatic cycle();
    int t0, t1, f;
    logic esclk, elrck, estb;
    @(posedge clk);
    if (live) begin
      n_edge++;
      if (armed_load) begin
        exp_q.push_back(frame_of(snd, mute));
        armed_load = 0;
      end
    end
    @(negedge clk);
    if (live) begin
      t0 = (16 * n_edge) / 125;
      t1 = (16 * (n_edge + 1)) / 125;
      f  = t0 / 2;
      esclk = ((t0 % 2) == 1);
      elrck = (f == 0) ? 1'b1 : (((f - 1) % 64) >= 32);
      estb  = (t1 != t0) && ((t0 % 2) == 1) && ((f % 64) == 1);
      if (sclk !== esclk || lrck !== elrck || stb !== estb) begin
        if (tmis == 0)
          $display("timing diverges at edge %0d: sclk %b/%b lrck %b/%b stb %b/%b",
                   n_edge, sclk, esclk, lrck, elrck, stb, estb);
        tmis++;
      end
      if (sclk !== prev_sclk) tog++;
      if (sclk && !prev_sclk) begin
        rises++;
        seg_rises++;
        if (first_rise < 0) first_rise = n_edge;
      end
      if (lrck !== prev_lrck) begin
        if (seg_open) begin
          seg_cnt++;
          if (seg_rises != 32) seg_bad++;
        end
        seg_open  = 1;
        seg_rises = 0;
      end
      if (stb) begin
        stbs++;
        if (first_stb < 0) first_stb = n_edge;
        if (last_stb >= 0) begin
          intervals++;
          if (n_edge - last_stb != 1000) bad_int++;
        end
        last_stb   = n_edge;
        armed_load = 1;
        armed      = 1;
      end
      if (!sclk && prev_sclk) begin
        if (armed) begin
          armed = 0; collecting = 1; bit_n = 0;
        end
        if (collecting) begin
          obs = {obs[62:0], dac};
          bit_n++;
          if (bit_n == 64) begin
            collecting = 0;
            check_frame();
          end
        end else if (dac !== 1'b0) begin
          tmis++;
        end
      end
      prev_sclk = sclk;
      prev_lrck = lrck;
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic wait_stb();
    bit found = 0;
    for (int c = 0; c < 1100 && !found; c++) begin
      cycle();
      if (stb) found = 1;
    end
    if (!found) timeout("wait_stb");
  endtask

  task automatic wait_frames(input int target);
    for (int c = 0; c < 2500 && frames_done < target; c++) cycle();
    if (frames_done < target) timeout("wait_frames");
  endtask

  task automatic wait_bit(input int target);
    for (int c = 0; c < 1100 && !(collecting && bit_n == target); c++) cycle();
    if (!(collecting && bit_n == target)) timeout("wait_bit");
  endtask

  task automatic release_reset();
    rst_n = 1'b1;
    live  = 1;
    clear_stats();
  endtask

  task automatic check_startup_window(input string tag);
    run(1000);
    chk({tag, "_ticks"}, 64'(tog), 64'd128);
    chk({tag, "_sclk_rises"}, 64'(rises), 64'd64);
    chk({tag, "_stb_count"}, 64'(stbs), 64'd1);
    chk({tag, "_first_tick_edge"}, 64'(first_rise), 64'd8);
    chk({tag, "_first_stb_edge"}, 64'(first_stb), 64'd31);
    chk({tag, "_timing"}, 64'(tmis), 64'd0);
  endtask

  initial begin
    int fd;
    rst_n = 1'b0;
    snd   = 16'h8001;
    mute  = 1'b0;
    frames_done = 0; intervals = 0; bad_int = 0; seg_cnt = 0; seg_bad = 0;
    obs = '0; last_frame = '0;
    bench_reset_state();
    clear_stats();
    run(3);
    chk("reset_sclk", 64'(sclk), 64'd0);
    chk("reset_lrck", 64'(lrck), 64'd1);
    chk("reset_dac", 64'(dac), 64'd0);
    chk("reset_stb", 64'(stb), 64'd0);

    // Start-up: tick count, first tick and first strobe position.
    release_reset();
    check_startup_window("startup");

    // Steady 16'h8001: left and right slots carry the raw sample.
    wait_frames(2);
    chk("frame_8001", last_frame, 64'h8001_0000_8001_0000);

    // Mute mid-frame: current frame untouched, next frame silent.
    clear_stats();
    wait_stb();
    fd = frames_done;
    run(500);
    mute = 1'b1;
    wait_frames(fd + 1);
    chk("mute_current_frame", last_frame, 64'h8001_0000_8001_0000);
    wait_frames(fd + 2);
    chk("mute_next_frame", last_frame, 64'h0);
    chk("mute_timing", 64'(tmis), 64'd0);
    mute = 1'b0;

    // Mute raised in the load clock itself: that load is silent.
    wait_stb();
    fd = frames_done;
    mute = 1'b1;
    cycle();
    mute = 1'b0;
    wait_frames(fd + 1);
    chk("mute_at_load", last_frame, 64'h0);
    wait_frames(fd + 2);
    chk("unmute_frame", last_frame, 64'h8001_0000_8001_0000);

    // Data step at bit 10: no torn word, new value next frame.
    snd = 16'h1234;
    wait_stb();
    fd = frames_done;
    wait_bit(10);
    snd = 16'hFFFF;
    wait_frames(fd + 1);
    chk("step_old_frame", last_frame, 64'h1234_0000_1234_0000);
    wait_frames(fd + 2);
    chk("step_new_frame", last_frame, 64'hFFFF_0000_FFFF_0000);

    // Long run with random data/mute: strobe spacing and LRCK duty.
    clear_stats();
    intervals = 0; bad_int = 0; seg_cnt = 0; seg_bad = 0;
    for (int c = 0; c < 32000 && intervals < 30; c++) begin
      if ($urandom_range(0, 299) == 0) snd = 16'($urandom);
      if ($urandom_range(0, 499) == 0) mute = ($urandom_range(0, 3) == 0);
      cycle();
    end
    chk("stb_intervals", 64'(intervals), 64'd30);
    chk("stb_interval_bad", 64'(bad_int), 64'd0);
    chk("lrck_segments_seen", 64'(seg_cnt >= 58), 64'd1);
    chk("lrck_segment_bad", 64'(seg_bad), 64'd0);
    chk("long_timing", 64'(tmis), 64'd0);

    // Reset in the middle of the right slot, bit 40, SCLK high, DAC high.
    mute = 1'b0;
    snd  = 16'hFFFF;
    wait_stb();
    wait_bit(40);
    for (int c = 0; c < 20 && sclk !== 1'b1; c++) cycle();
    chk("pre_reset_sclk", 64'(sclk), 64'd1);
    chk("pre_reset_dac", 64'(dac), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_sclk", 64'(sclk), 64'd0);
    chk("async_reset_lrck", 64'(lrck), 64'd1);
    chk("async_reset_dac", 64'(dac), 64'd0);
    chk("async_reset_stb", 64'(stb), 64'd0);
    bench_reset_state();
    run(3);
    release_reset();
    check_startup_window("restart");
    wait_frames(frames_done + 1);
    chk("restart_frame", last_frame, 64'hFFFF_0000_FFFF_0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
